// File: rtl/e_mdu_pkg.sv
// Shared MDU op codes and the arithmetic helpers used by the execute-stage MDU.
// The D-stage decoder and hazard unit import the same op encoding.
package e_mdu_pkg;

  localparam int MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  // Low 64 bits of the product of the extended operands is the exact result.
  function automatic logic [63:0] mdu_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}; b==0 is screened out by the caller.
  function automatic logic [63:0] mdu_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: result computed at accept, committed to
// HI/LO when the busy down-counter expires.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  output logic                busy,
  output logic [31:0]         out,
  output logic [31:0]         HI,
  output logic [31:0]         LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic [63:0]      w_mul;
  logic [63:0]      w_div;

  assign w_mul = mdu_mul(A, B, op == MDU_MULT);
  assign w_div = mdu_div(A, B, op == MDU_DIV);
  assign busy  = (r_cnt != '0);
  assign HI    = r_hi;
  assign LO    = r_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (start) begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          {r_pend_hi, r_pend_lo} <= w_mul;
          r_cnt                  <= CNT_W'(MULT_CYCLES);
        end
        MDU_DIV, MDU_DIVU: begin
          // Divide by zero still occupies the unit but commits the old HI/LO.
          if (B == 32'd0) {r_pend_hi, r_pend_lo} <= {r_hi, r_lo};
          else            {r_pend_hi, r_pend_lo} <= w_div;
          r_cnt <= CNT_W'(DIV_CYCLES);
        end
        MDU_MTHI: r_hi <= A;
        MDU_MTLO: r_lo <= A;
        default: ;
      endcase
    end
  end

  always_comb begin
    out = '0;
    case (op)
      MDU_MFHI: out = r_hi;
      MDU_MFLO: out = r_lo;
      default:  out = '0;
    endcase
  end

  // The hazard unit must never issue while busy; such a start is dropped.
  always @(posedge clk) begin
    if (reset) begin
      assert (!(start && busy)) else $warning("e_mdu: start while busy dropped");
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: issue side predicts HI/LO with plain integer
// arithmetic, a negedge monitor retires predictions as the DUT completes them.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef longint unsigned u64_t;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;
  typedef struct {
    logic [3:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } dir_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] out;
  logic [31:0] HI;
  logic [31:0] LO;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .out(out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] s_hi, s_lo;
  logic [31:0] m_hi, m_lo;
  bit          mon_en = 1'b0;
  int          bcnt;
  bit          prev_busy;
  bit          acc_mt;
  exp_t        me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [3:0] o, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] hi,
                                     input logic [31:0] lo);
    exp_t   e;
    longint p;
    u64_t   pu;
    int     q, r;
    e.hi = hi; e.lo = lo; e.len = 0;
    case (o)
      MDU_MULT: begin
        p = longint'(int'(a)) * longint'(int'(b));
        e.hi = p[63:32]; e.lo = p[31:0]; e.len = MC;
      end
      MDU_MULTU: begin
        pu = u64_t'(a) * u64_t'(b);
        e.hi = pu[63:32]; e.lo = pu[31:0]; e.len = MC;
      end
      MDU_DIV: begin
        e.len = DC;
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = a; e.hi = 0;
          end else begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            e.lo = q; e.hi = r;
          end
        end
      end
      MDU_DIVU: begin
        e.len = DC;
        if (b != 0) begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      MDU_MTHI: e.hi = a;
      MDU_MTLO: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    chk("wait_idle_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit use_exp, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    wait_idle();
    e = ref_model(o, a, b, s_hi, s_lo);
    if (use_exp) begin
      e.hi = ehi; e.lo = elo;
    end
    s_hi = e.hi; s_lo = e.lo;
    if (o inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO})
      sb.push_back(e);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor: retires a prediction on busy falling or after an accepted MTHI/MTLO,
  // and checks HI/LO/out against the committed state every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb.delete();
        m_hi = 0; m_lo = 0; bcnt = 0; prev_busy = 0; acc_mt = 0;
      end else if (mon_en) begin
        if (acc_mt || (prev_busy && !busy)) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow actual=completion expected=none t=%0t", $time);
          end else begin
            me = sb.pop_front();
            chk("busy_len", 32'(bcnt), 32'(me.len));
            m_hi = me.hi; m_lo = me.lo;
          end
          bcnt = 0;
        end
        if (busy) bcnt++;
        chk("HI", HI, m_hi);
        chk("LO", LO, m_lo);
        chk("out", out, (op == MDU_MFHI) ? m_hi : (op == MDU_MFLO) ? m_lo : 32'd0);
        acc_mt    = start && !busy && (op == MDU_MTHI || op == MDU_MTLO);
        prev_busy = busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  dir_t dirs[9];
  logic [3:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    dirs = '{
      '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA},
      '{MDU_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA},
      '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{MDU_DIVU,  32'd7,         32'd2,         32'd1,         32'd3},
      '{MDU_MTHI,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'd3},
      '{MDU_MFHI,  32'd0,         32'd0,         32'h1234_5678, 32'd3},
      '{MDU_MTLO,  32'h0000_AAAA, 32'd0,         32'h1234_5678, 32'h0000_AAAA},
      '{MDU_DIV,   32'd5,         32'd0,         32'h1234_5678, 32'h0000_AAAA},
      '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000}
    };
    reset = 1'b0; start = 1'b0; op = MDU_NONE; A = 0; B = 0;
    s_hi = 0; s_lo = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_out", out, 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    foreach (dirs[i]) issue(dirs[i].o, dirs[i].a, dirs[i].b, 1'b1, dirs[i].hi, dirs[i].lo);

    // Dropped start and stale MFLO read while a divide is in flight.
    issue(MDU_DIV, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    start = 1'b1; op = MDU_MULT; A = 32'd2; B = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_MFLO;
    wait_idle();
    @(posedge clk); #1;
    chk("div_after_ignored_lo", LO, 32'd14);
    chk("div_after_ignored_hi", HI, 32'd2);

    // Async reset in the middle of a multiply.
    issue(MDU_MULT, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_HI", HI, 32'd0);
    chk("midrst_LO", LO, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    s_hi = 0; s_lo = 0;
    op = MDU_MFLO;
    @(posedge clk); #1;
    chk("mflo_after_reset", out, 32'd0);
    issue(MDU_MULT, 32'd4, 32'd4, 1'b1, 32'd0, 32'd16);

    for (int n = 0; n < 50; n++) begin
      ro = 4'($urandom_range(1, 15));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 17));
        3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb, 1'b0, 32'd0, 32'd0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_HI", HI, s_hi);
    chk("final_LO", LO, s_lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
